// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_pkg
// Description : Shared definitions for the RTC bus arbiter: requester
//               indices, FSM state encoding and default bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

  // Default RTC address / data widths
  localparam int RTC_AW = 8;
  localparam int RTC_DW = 8;

  // Requester indices, in descending priority order
  localparam logic [1:0] REQ_INIT = 2'd0;
  localparam logic [1:0] REQ_RST  = 2'd1;
  localparam logic [1:0] REQ_WR   = 2'd2;
  localparam logic [1:0] REQ_RD   = 2'd3;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } rtc_state_e;

endpackage : rtc_pkg
`default_nettype wire

// File: rtl/rtc_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : rtc_prio_enc
// Description : Combinational 4-input fixed-priority encoder (index 0 wins)
//               with a lock override: a valid lock owner that is still
//               requesting wins regardless of priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_prio_enc
  import rtc_pkg::*;
(
  input  logic [3:0] i_req,
  input  logic       i_lock_valid,
  input  logic [1:0] i_lock_id,
  output logic [1:0] o_gnt_id,
  output logic       o_gnt_valid
);

  // Pick the lock owner if it still requests, otherwise the lowest active index
  always_comb begin
    o_gnt_id    = REQ_INIT;
    o_gnt_valid = |i_req;
    if (i_lock_valid && i_req[i_lock_id]) begin
      o_gnt_id = i_lock_id;
    end else if (i_req[0]) begin
      o_gnt_id = REQ_INIT;
    end else if (i_req[1]) begin
      o_gnt_id = REQ_RST;
    end else if (i_req[2]) begin
      o_gnt_id = REQ_WR;
    end else begin
      o_gnt_id = REQ_RD;
    end
  end

endmodule : rtc_prio_enc
`default_nettype wire

// File: rtl/rtc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rtc_bus_arbiter
// Description : Fixed-priority arbiter sharing the RTC protocol engine
//               between init, register-reset, write and read requesters.
//               Request/ack handshake, locked bursts, registered outputs.
//               Optional engine-done watchdog: define RTC_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_arbiter
  import rtc_pkg::*;
#(
  parameter int AW             = RTC_AW,
  parameter int DW             = RTC_DW,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic [3:0]      req,
  input  logic [3:0]      lock,
  input  logic [4*AW-1:0] req_addr,
  input  logic [4*DW-1:0] req_wdata,
  input  logic [3:0]      req_wr,
  output logic [3:0]      ack,
  output logic [DW-1:0]   rd_data,
  output logic [1:0]      grant_id,
  output logic            busy,
  output logic            eng_start,
  output logic [AW-1:0]   eng_addr,
  output logic [DW-1:0]   eng_wdata,
  output logic            eng_wr,
  input  logic            eng_done,
  input  logic [DW-1:0]   eng_rdata,
  output logic            err
);

  rtc_state_e r_state;
  logic       r_lock_valid;
  logic [1:0] r_lock_id;
  logic [1:0] w_gnt_id;
  logic       w_gnt_valid;

  rtc_prio_enc u_prio_enc (
    .i_req        (req),
    .i_lock_valid (r_lock_valid),
    .i_lock_id    (r_lock_id),
    .o_gnt_id     (w_gnt_id),
    .o_gnt_valid  (w_gnt_valid)
  );

`ifdef RTC_ARB_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_cnt_w-1:0] r_to_cnt;
  logic               w_timeout;
  // Last permitted WAIT cycle without eng_done
  assign w_timeout = (r_to_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
  assign err          = 1'b0;
`endif

  // Arbitration FSM; every output is a register updated here
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= ST_IDLE;
      r_lock_valid <= 1'b0;
      r_lock_id    <= REQ_INIT;
      ack          <= '0;
      rd_data      <= '0;
      grant_id     <= REQ_INIT;
      busy         <= 1'b0;
      eng_start    <= 1'b0;
      eng_addr     <= '0;
      eng_wdata    <= '0;
      eng_wr       <= 1'b0;
`ifdef RTC_ARB_TIMEOUT_EN
      r_to_cnt     <= '0;
      err          <= 1'b0;
`endif
    end else begin
      // Pulses default low; each state raises them for one cycle only
      eng_start <= 1'b0;
      ack       <= '0;
      case (r_state)
        ST_IDLE: begin
          // Owner stopped requesting: the burst is over
          if (r_lock_valid && !req[r_lock_id]) begin
            r_lock_valid <= 1'b0;
          end
          if (w_gnt_valid) begin
            grant_id  <= w_gnt_id;
            eng_addr  <= req_addr[int'(w_gnt_id)*AW +: AW];
            eng_wdata <= req_wdata[int'(w_gnt_id)*DW +: DW];
            eng_wr    <= req_wr[w_gnt_id];
            busy      <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          eng_start <= 1'b1;
`ifdef RTC_ARB_TIMEOUT_EN
          r_to_cnt  <= '0;
`endif
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (eng_done) begin
            if (!eng_wr) begin
              rd_data <= eng_rdata;
            end
            ack[grant_id] <= 1'b1;
            r_state       <= ST_ACK;
          end
`ifdef RTC_ARB_TIMEOUT_EN
          else if (w_timeout) begin
            // Abort but still ack so the requester cannot hang
            err <= 1'b1;
            if (!eng_wr) begin
              rd_data <= '1;
            end
            ack[grant_id] <= 1'b1;
            r_state       <= ST_ACK;
          end else begin
            r_to_cnt <= r_to_cnt + c_cnt_w'(1);
          end
`endif
        end
        ST_ACK: begin
          r_lock_valid <= lock[grant_id];
          r_lock_id    <= grant_id;
          busy         <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule : rtc_bus_arbiter
`default_nettype wire

// File: tb/tb_rtc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_bus_arbiter
// Description : Scoreboard bench for rtc_bus_arbiter with a behavioural
//               protocol engine (read data = address ^ 8'h64).
//               Timeout cases are compiled in with RTC_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_arbiter;

`ifdef RTC_ARB_TIMEOUT_EN
  localparam int c_to = 16;
`else
  localparam int c_to = 1024;
`endif

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  lock = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wr = '0;
  logic [3:0]  ack;
  logic [7:0]  rd_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        eng_start;
  logic [7:0]  eng_addr;
  logic [7:0]  eng_wdata;
  logic        eng_wr;
  logic        eng_done = 1'b0;
  logic [7:0]  eng_rdata = '0;
  logic        err;

  rtc_bus_arbiter #(.AW(8), .DW(8), .TIMEOUT_CYCLES(c_to)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .req       (req),
    .lock      (lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wr    (req_wr),
    .ack       (ack),
    .rd_data   (rd_data),
    .grant_id  (grant_id),
    .busy      (busy),
    .eng_start (eng_start),
    .eng_addr  (eng_addr),
    .eng_wdata (eng_wdata),
    .eng_wr    (eng_wr),
    .eng_done  (eng_done),
    .eng_rdata (eng_rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cyc = -100;
  int start_cyc = -100;
  int eng_delay = 5;
  bit eng_mute  = 1'b0;
  logic [7:0] eng_a;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] rd;
    logic       lat;
  } exp_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       wr;
  } eng_t;

  exp_t exp_q[$];
  eng_t eng_q[$];
  exp_t me;
  eng_t mg;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural engine: done eng_delay cycles after the start cycle
  always begin
    @(negedge clk);
    if (eng_start && !eng_mute) begin
      eng_a = eng_addr;
      repeat (eng_delay) @(posedge clk);
      #1;
      if (!eng_mute) begin
        eng_done  = 1'b1;
        eng_rdata = eng_a ^ 8'h64;
        done_cyc  = cyc;
        @(posedge clk);
        #1 eng_done = 1'b0;
      end
    end
  end

  // Monitor: engine issue and requester ack checked against the queues
  always @(negedge clk) begin
    if (Reset && eng_start) begin
      start_cyc = cyc;
      total++;
      if (eng_q.size() == 0) begin
        bad++;
        $display("FAIL eng_issue: unexpected eng_start addr=%h", eng_addr);
      end else begin
        mg = eng_q.pop_front();
        if (eng_addr !== mg.addr || eng_wr !== mg.wr ||
            (mg.wr && eng_wdata !== mg.wdata)) begin
          bad++;
          $display("FAIL eng_issue: got addr=%h wd=%h wr=%b need addr=%h wd=%h wr=%b",
                   eng_addr, eng_wdata, eng_wr, mg.addr, mg.wdata, mg.wr);
        end
      end
    end
    if (Reset && ack != 4'b0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL ack_resp: unexpected ack=%b", ack);
      end else begin
        me = exp_q.pop_front();
        if (ack !== (4'b1 << me.id) || grant_id !== me.id ||
            rd_data !== me.rd || busy !== 1'b1) begin
          bad++;
          $display("FAIL ack_resp: got ack=%b gid=%0d rd=%h busy=%b need ack=%b gid=%0d rd=%h busy=1",
                   ack, grant_id, rd_data, busy, 4'b1 << me.id, me.id, me.rd);
        end
        if (me.lat) begin
          total++;
          if (cyc != done_cyc + 1) begin
            bad++;
            $display("FAIL ack_latency: got %0d cycles after done, need 1", cyc - done_cyc);
          end
        end
      end
    end
  end

  task automatic set_slot(input int idx, input logic [7:0] a, input logic [7:0] d,
                          input logic wr);
    req_addr[idx*8 +: 8]  = a;
    req_wdata[idx*8 +: 8] = d;
    req_wr[idx]           = wr;
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] rd, input logic lat);
    exp_q.push_back('{id: id, rd: rd, lat: lat});
  endtask

  task automatic push_eng(input logic [7:0] a, input logic [7:0] d, input logic wr);
    eng_q.push_back('{addr: a, wdata: d, wr: wr});
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] need);
    total++;
    if (got !== need) begin
      bad++;
      $display("FAIL %s: got %h need %h", nm, got, need);
    end
  endtask

  task automatic wait_ack(input int idx, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack[idx] !== 1'b1 && n < 100);
    total++;
    if (ack[idx] !== 1'b1) begin
      bad++;
      $display("FAIL %s: ack[%0d] not seen in %0d cycles, got 0 need 1", nm, idx, n);
    end
  endtask

  task automatic wait_start(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (eng_start !== 1'b1 && n < 100);
    total++;
    if (eng_start !== 1'b1) begin
      bad++;
      $display("FAIL %s: eng_start not seen in %0d cycles, got 0 need 1", nm, n);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({ack, rd_data, grant_id, busy, eng_start,
                                eng_addr, eng_wdata, eng_wr, err}), 64'd0);
    Reset = 1'b1;
    tick();

    // Single read with 5-cycle engine latency
    set_slot(3, 8'h21, 8'h00, 1'b0);
    push_eng(8'h21, 8'h00, 1'b0);
    push_exp(2'd3, 8'h45, 1'b1);
    t = cyc;
    req[3] = 1'b1;
    wait_start("read_start");
    check("start_latency", 64'(cyc - t), 64'd2);
    wait_ack(3, "read_ack");
    tick();
    req[3] = 1'b0;
    eng_delay = 2;

    // Contention: write wins, read follows; write keeps rd_data
    set_slot(2, 8'h30, 8'hA5, 1'b1);
    set_slot(3, 8'h10, 8'h00, 1'b0);
    push_eng(8'h30, 8'hA5, 1'b1);
    push_eng(8'h10, 8'h00, 1'b0);
    push_exp(2'd2, 8'h45, 1'b1);
    push_exp(2'd3, 8'h74, 1'b1);
    req = 4'b1100;
    wait_ack(2, "cont_wr_ack");
    tick();
    req[2] = 1'b0;
    wait_ack(3, "cont_rd_ack");
    tick();
    req[3] = 1'b0;

    // Locked init burst of three writes with a pending read
    set_slot(3, 8'h55, 8'h00, 1'b0);
    set_slot(0, 8'h01, 8'h11, 1'b1);
    push_eng(8'h01, 8'h11, 1'b1);
    push_eng(8'h02, 8'h22, 1'b1);
    push_eng(8'h03, 8'h33, 1'b1);
    push_eng(8'h55, 8'h00, 1'b0);
    push_exp(2'd0, 8'h74, 1'b1);
    push_exp(2'd0, 8'h74, 1'b1);
    push_exp(2'd0, 8'h74, 1'b1);
    push_exp(2'd3, 8'h31, 1'b1);
    lock[0] = 1'b1;
    req     = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      wait_ack(0, "burst_ack");
      tick();
      if (k == 0) set_slot(0, 8'h02, 8'h22, 1'b1);
      if (k == 1) begin
        set_slot(0, 8'h03, 8'h33, 1'b1);
        lock[0] = 1'b0;
      end
      if (k == 2) req[0] = 1'b0;
    end
    wait_ack(3, "burst_rd_ack");
    tick();
    req[3] = 1'b0;

    // Init arriving during a read's WAIT does not preempt it
    set_slot(3, 8'h40, 8'h00, 1'b0);
    push_eng(8'h40, 8'h00, 1'b0);
    push_eng(8'h7F, 8'h5A, 1'b1);
    push_exp(2'd3, 8'h24, 1'b1);
    push_exp(2'd0, 8'h24, 1'b1);
    req[3] = 1'b1;
    wait_start("nopre_start");
    tick();
    set_slot(0, 8'h7F, 8'h5A, 1'b1);
    req[0] = 1'b1;
    wait_ack(3, "nopre_rd_ack");
    tick();
    req[3] = 1'b0;
    wait_ack(0, "nopre_init_ack");
    tick();
    req[0] = 1'b0;

    // Lock owner (read) keeps the grant over a higher-priority init
    set_slot(3, 8'h08, 8'h00, 1'b0);
    push_eng(8'h08, 8'h00, 1'b0);
    push_eng(8'h0A, 8'h00, 1'b0);
    push_eng(8'h09, 8'h99, 1'b1);
    push_exp(2'd3, 8'h6C, 1'b1);
    push_exp(2'd3, 8'h6E, 1'b1);
    push_exp(2'd0, 8'h6E, 1'b1);
    lock[3] = 1'b1;
    req[3]  = 1'b1;
    wait_start("lockov_start");
    tick();
    set_slot(0, 8'h09, 8'h99, 1'b1);
    req[0] = 1'b1;
    wait_ack(3, "lockov_rd1_ack");
    tick();
    set_slot(3, 8'h0A, 8'h00, 1'b0);
    lock[3] = 1'b0;
    wait_ack(3, "lockov_rd2_ack");
    tick();
    req[3] = 1'b0;
    wait_ack(0, "lockov_init_ack");
    tick();
    req[0] = 1'b0;

    // Reset asserted mid-WAIT: outputs clear at once, no ack
    eng_mute = 1'b1;
    set_slot(1, 8'h77, 8'hC3, 1'b1);
    push_eng(8'h77, 8'hC3, 1'b1);
    req[1] = 1'b1;
    wait_start("rst_start");
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    #1;
    check("midreset_outputs", 64'({ack, rd_data, grant_id, busy, eng_start,
                                   eng_addr, eng_wdata, eng_wr, err}), 64'd0);
    req[1] = 1'b0;
    repeat (2) @(negedge clk);
    Reset    = 1'b1;
    eng_mute = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_idle", 64'({busy, grant_id, eng_start, ack}), 64'd0);
    tick();
    set_slot(1, 8'h66, 8'h12, 1'b1);
    push_eng(8'h66, 8'h12, 1'b1);
    push_exp(2'd1, 8'h00, 1'b1);
    req[1] = 1'b1;
    wait_ack(1, "post_reset_ack");
    tick();
    req[1] = 1'b0;

`ifdef RTC_ARB_TIMEOUT_EN
    // Engine never answers a read: abort after 16 WAIT cycles
    eng_mute = 1'b1;
    set_slot(3, 8'h5E, 8'h00, 1'b0);
    push_eng(8'h5E, 8'h00, 1'b0);
    push_exp(2'd3, 8'hFF, 1'b0);
    req[3] = 1'b1;
    wait_start("to_start");
    t = cyc;
    wait_ack(3, "to_ack");
    check("to_latency", 64'(cyc - t), 64'd16);
    check("to_err_set", 64'(err), 64'd1);
    tick();
    req[3] = 1'b0;
    repeat (5) @(negedge clk);
    check("to_err_sticky", 64'(err), 64'd1);
    Reset = 1'b0;
    @(negedge clk);
    check("to_err_cleared", 64'(err), 64'd0);
    Reset    = 1'b1;
    eng_mute = 1'b0;
`else
    check("err_tied_low", 64'(err), 64'd0);
`endif

    repeat (4) @(negedge clk);
    check("queues_drained", 64'(exp_q.size() + eng_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rtc_bus_arbiter
`default_nettype wire

// File: doc/rtc_bus_arbiter.md
Name: rtc_bus_arbiter

Overview:
Shares the single parallel RTC protocol engine between four requesters: power-up init, register reset, user edit/write, and permanent read. It replaces the ad-hoc address/data muxing ahead of the protocol engine with a fixed-priority arbiter. The arbiter supports an explicit request/ack handshake and locked bursts. It sits between the requester FSMs and the RTC protocol engine, and returns read data to the VGA register bank.

Parameters:
AW, 8, RTC address width
DW, 8, RTC data width
TIMEOUT_CYCLES, 1024, engine-done watchdog limit (used only with RTC_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
req  in  4  request per requester; index 0=init, 1=reset, 2=write, 3=read
lock  in  4  hold grant after the current access (burst); sampled at ack
req_addr  in  4*AW  per-requester RTC address; slice i is requester i
req_wdata  in  4*DW  per-requester write data
req_wr  in  4  1=write, 0=read, per requester
ack  out  4  one-cycle pulse to the granted requester when its access completes
rd_data  out  DW  read data, valid in the ack cycle of a read
grant_id  out  2  currently or last granted requester
busy  out  1  high from grant until return to IDLE
eng_start  out  1  one-cycle start pulse to the protocol engine
eng_addr  out  AW  latched address to the engine
eng_wdata  out  DW  latched write data
eng_wr  out  1  latched direction
eng_done  in  1  one-cycle completion pulse from the engine
eng_rdata  in  DW  engine read data, valid with eng_done
err  out  1  sticky timeout flag; cleared only by Reset

Behaviour:
- Reset (Reset=0, async): state IDLE.
  - All outputs go to 0: ack, rd_data, grant_id, busy, eng_start, eng_addr, eng_wdata, eng_wr, err.
  - Lock owner is cleared.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If a lock owner exists and its req=1, grant it regardless of priority.
  - Otherwise grant the lowest-index active req. Priority is init > reset > write > read.
  - On grant: latch the addr/wdata/wr slice, set grant_id, busy=1, and go to ISSUE.
  - With no req, stay in IDLE with busy=0.
- ISSUE: assert eng_start for exactly one cycle, then go to WAIT.
- WAIT:
  - Hold eng_* stable.
  - On eng_done: capture eng_rdata into rd_data if eng_wr=0 (rd_data holds otherwise), then go to ACK.
- ACK:
  - Pulse ack[grant_id] for one cycle.
  - If lock[grant_id]=1, record the lock owner; otherwise clear it.
  - Go to IDLE with busy=0.
- Latency: req seen in IDLE at cycle t gives eng_start at t+2, and ack one cycle after eng_done.
- A requester must hold req, addr, data and wr until its ack; inputs are latched at grant.
- Dropping req before ack does not abort the access. The access completes and ack is still pulsed.
- Lock owner drops req in IDLE: the lock is released and normal priority applies in the same cycle.
- Simultaneous req from several requesters: exactly one grant, chosen by priority (or by the lock owner).
- eng_done while not in WAIT is ignored.
- Reset asserted mid-access: immediate return to IDLE with no ack. The engine is expected to be reset by the same Reset.

Optional Feature:
RTC_ARB_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES without eng_done, the access is aborted: err is set (sticky), the FSM goes to ACK, and ack is still pulsed so the requester does not hang.
  - On a read abort, rd_data is forced to 8'hFF.
- Not defined: no counter is built, err is tied to 0, and WAIT waits indefinitely.

Decomposition:
- Shared package rtc_pkg:
  - Requester index constants: REQ_INIT=0, REQ_RST=1, REQ_WR=2, REQ_RD=3.
  - State encoding typedef.
  - AW/DW defaults.
- One natural sub-module: rtc_prio_enc, a combinational 4-input priority encoder with a lock override, producing a grant index and a valid flag.

Test Plan:
- Single read: req[3]=1, addr=8'h21; engine returns eng_done with rdata=8'h45 five cycles after start -> eng_start 2 cycles after req, eng_wr=0, ack[3] one cycle after done, rd_data=8'h45.
- Contention: req=4'b1100 in the same cycle -> write (index 2) granted first; read granted after ack[2]; grant_id goes 2 then 3.
- Locked burst: init issues 3 writes with lock[0]=1 while req[3] is held high -> all 3 init writes complete back-to-back before any read grant; read is granted after lock[0]=0.
- Init over read: req[3] already granted and in WAIT, then req[0] rises -> the read completes and acks first, then init is granted; no preemption.
- Reset mid-WAIT: Reset=0 during WAIT -> all outputs 0 immediately, no ack, IDLE after release.
- With RTC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, eng_done never arrives for a read -> after 16 WAIT cycles err=1, ack pulsed, rd_data=8'hFF; err stays 1 until Reset.
